// File: rtl/priority_encoder_pkg.sv
// Shared widths, index codes and the output bundle type for the sampled
// 4-to-2 priority encoder.
package priority_encoder_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned N_REQ = 4;

  typedef enum logic [IDX_W-1:0] {
    IDX_D0 = 2'b00,
    IDX_D1 = 2'b01,
    IDX_D2 = 2'b10,
    IDX_D3 = 2'b11
  } idx_e;

  typedef struct packed {
    logic a;
    logic b;
    logic v;
  } enc_t;

  localparam enc_t ENC_RST = 3'b000;

endpackage

// File: rtl/priority_encoder_sync_if.sv
// Request lines in, encoded index and valid out; master drives requests.
interface priority_encoder_sync_if;

  logic d0;
  logic d1;
  logic d2;
  logic d3;
  logic a;
  logic b;
  logic v;

  modport master (output d0, d1, d2, d3, input a, b, v);
  modport slave  (input d0, d1, d2, d3, output a, b, v);

endinterface

// File: rtl/priority_encoder_core.sv
// Combinational core: reduces d3..d0 to the index of the highest set line.
module priority_encoder_core
  import priority_encoder_pkg::*;
(
  priority_encoder_sync_if.slave bus
);

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] idx;

  always_comb begin
    req    = {bus.d3, bus.d2, bus.d1, bus.d0};
    idx    = '0;
    idx[1] = req[3] | req[2];
    // d1 only reaches the LSB when d2 does not outrank it
    idx[0] = req[3] | (req[1] & ~req[2]);
    bus.a  = idx[1];
    bus.b  = idx[0];
    bus.v  = |req;
  end

endmodule

// File: rtl/priority_encoder_sync.sv
// Priority encoder with optional async-reset output register (REG_OUT).
module priority_encoder_sync
  import priority_encoder_pkg::*;
#(
  parameter int unsigned REG_OUT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic a,
  output logic b,
  output logic v
);

  priority_encoder_sync_if core_if ();

  assign core_if.d0 = d0;
  assign core_if.d1 = d1;
  assign core_if.d2 = d2;
  assign core_if.d3 = d3;

  priority_encoder_core u_core (
    .bus (core_if.slave)
  );

  enc_t core_out;
  assign core_out = enc_t'({core_if.a, core_if.b, core_if.v});

  generate
    if (REG_OUT != 0) begin : g_reg
      enc_t out_d;
      enc_t out_q;

      always_comb begin
        out_d = core_out;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= ENC_RST;
        else        out_q <= out_d;
      end

      assign {a, b, v} = out_q;
    end else begin : g_comb
      // Bypass path still honours reset so outputs read 000 while rst_n=0
      assign {a, b, v} = rst_n ? core_out : ENC_RST;
    end
  endgenerate

endmodule

// File: tb/tb_priority_encoder_sync.sv
// Directed bench for priority_encoder_sync: registered and bypass instances.
module tb_priority_encoder_sync;
  import priority_encoder_pkg::*;

  logic clk;
  logic rst_n;
  logic rst0_n;
  int   tests;
  int   fails;
  logic [2:0] sb_q[$];

  priority_encoder_sync_if bus1 ();
  priority_encoder_sync_if bus0 ();

  priority_encoder_sync #(.REG_OUT(1)) dut (
    .clk (clk), .rst_n (rst_n),
    .d0 (bus1.d0), .d1 (bus1.d1), .d2 (bus1.d2), .d3 (bus1.d3),
    .a (bus1.a), .b (bus1.b), .v (bus1.v)
  );

  priority_encoder_sync #(.REG_OUT(0)) dut0 (
    .clk (clk), .rst_n (rst0_n),
    .d0 (bus0.d0), .d1 (bus0.d1), .d2 (bus0.d2), .d3 (bus0.d3),
    .a (bus0.a), .b (bus0.b), .v (bus0.v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan from the top line down, first hit wins.
  function automatic logic [2:0] model(input logic [3:0] d);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (d[i]) begin
        r = {2'(i), 1'b1};
        break;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic [3:0] d);
    {bus1.d3, bus1.d2, bus1.d1, bus1.d0} = d;
  endtask

  // Drive at the falling edge, queue the expectation, compare after the next rise.
  task automatic step(input string tag, input logic [3:0] d);
    @(negedge clk);
    drive1(d);
    sb_q.push_back(model(d));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard required entry", tag);
    end else begin
      check(tag, {bus1.a, bus1.b, bus1.v}, sb_q.pop_front());
    end
  endtask

  logic [3:0] multi [11];

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    rst0_n = 1'b1;
    drive1(4'b1111);
    {bus0.d3, bus0.d2, bus0.d1, bus0.d0} = 4'b0000;
    multi = '{4'b0011, 4'b0111, 4'b1111, 4'b0101, 4'b1001, 4'b1101,
              4'b1100, 4'b1110, 4'b1011, 4'b0110, 4'b1010};

    // Reset held with all requests up
    #1;
    check("reset_t0", {bus1.a, bus1.b, bus1.v}, ENC_RST);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {bus1.a, bus1.b, bus1.v}, ENC_RST);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", {bus1.a, bus1.b, bus1.v}, ENC_RST);
    @(posedge clk);
    #1;
    check("first_edge_after_reset", {bus1.a, bus1.b, bus1.v}, 3'b111);

    // Single-hot sweep
    step("hot_d0", 4'b0001);
    check("hot_d0_const", {bus1.a, bus1.b, bus1.v}, {IDX_D0, 1'b1});
    step("hot_d1", 4'b0010);
    step("hot_d2", 4'b0100);
    step("hot_d3", 4'b1000);
    step("all_zero", 4'b0000);
    check("all_zero_const", {bus1.a, bus1.b, bus1.v}, 3'b000);

    // Multi-hot priority
    foreach (multi[i]) step($sformatf("multi_%b", multi[i]), multi[i]);

    // Latency: change inputs between edges
    step("lat_0001", 4'b0001);
    @(negedge clk);
    drive1(4'b1000);
    #1;
    check("lat_hold", {bus1.a, bus1.b, bus1.v}, 3'b001);
    @(posedge clk);
    #1;
    check("lat_update", {bus1.a, bus1.b, bus1.v}, 3'b111);

    // Async reset between edges
    @(negedge clk);
    check("pre_async_rst", {bus1.a, bus1.b, bus1.v}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clear", {bus1.a, bus1.b, bus1.v}, 3'b000);
    @(posedge clk);
    #1;
    check("async_rst_held", {bus1.a, bus1.b, bus1.v}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    drive1(4'b0000);
    step("after_rst_zero", 4'b0100);

    // Bypass instance: same-timestep response
    for (int i = 0; i < 16; i++) begin
      logic [3:0] d;
      d = 4'(i);
      {bus0.d3, bus0.d2, bus0.d1, bus0.d0} = d;
      #1;
      check($sformatf("comb_%b", d), {bus0.a, bus0.b, bus0.v}, model(d));
    end
    rst0_n = 1'b0;
    #1;
    check("comb_reset", {bus0.a, bus0.b, bus0.v}, 3'b000);
    rst0_n = 1'b1;
    #1;
    check("comb_reset_release", {bus0.a, bus0.b, bus0.v}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
